// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory loader for the mips_16 core.
//
// Receives a framed byte stream (header N, 2N data bytes high-first, one XOR
// checksum byte), writes each 16-bit word into instruction memory, and
// releases the core from reset only after a frame with a good checksum.
//
// Ports
//   clk          : single clock, rising-edge active
//   reset        : asynchronous, active-low reset
//   start        : one-cycle re-arm request, honoured only in DONE/ERR
//   in_valid     : byte-stream valid
//   in_data      : byte-stream data
//   in_ready     : byte-stream ready (registered)
//   mem_we       : instruction-memory write strobe (one cycle per word)
//   mem_addr     : instruction-memory word address
//   mem_wdata    : instruction word being written
//   cpu_run      : high lets the core execute; low holds it in reset
//   load_done    : last load completed with a good checksum
//   load_err     : last load failed its checksum
//   words_loaded : words written in the current or last load
//
// The header is one byte, so ADDR_W is expected to be at least 8.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t            state_r;
  logic [7:0]        n_r;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] idx_r;
  logic [CNT_W-1:0]  words_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [15:0]       wdata_r;
  logic              cpu_run_r;
  logic              load_done_r;
  logic              load_err_r;
  logic              xfer_s;
  logic              last_word_s;

  // Header value expanded to a word count; a header of 0 means 2^ADDR_W words.
  function automatic logic [CNT_W-1:0] frame_len(input logic [7:0] hdr);
    if (hdr == 8'd0) begin
      frame_len = {1'b1, {ADDR_W{1'b0}}};
    end else begin
      frame_len = {{(CNT_W-8){1'b0}}, hdr};
    end
  endfunction

  // Running checksum update: plain XOR of every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    csum_next = acc ^ b;
  endfunction

  // Handshake and end-of-frame detection.
  always_comb begin
    xfer_s      = in_valid & in_ready_r;
    last_word_s = ((words_r + {{(CNT_W-1){1'b0}}, 1'b1}) == frame_len(n_r));
  end

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= HDR;
      n_r         <= 8'd0;
      csum_r      <= 8'd0;
      idx_r       <= {ADDR_W{1'b0}};
      words_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      wdata_r     <= 16'd0;
      cpu_run_r   <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      case (state_r)
        HDR: begin
          // in_ready is low straight out of reset; it rises on the first edge.
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            n_r     <= in_data;
            csum_r  <= 8'd0;
            idx_r   <= {ADDR_W{1'b0}};
            words_r <= {CNT_W{1'b0}};
            state_r <= HI;
          end
        end
        HI: begin
          if (xfer_s) begin
            wdata_r[15:8] <= in_data;
            csum_r        <= csum_next(csum_r, in_data);
            state_r       <= LO;
          end
        end
        LO: begin
          if (xfer_s) begin
            wdata_r[7:0] <= in_data;
            csum_r       <= csum_next(csum_r, in_data);
            in_ready_r   <= 1'b0;
            mem_we_r     <= 1'b1;
            state_r      <= WR;
          end
        end
        WR: begin
          mem_we_r   <= 1'b0;
          in_ready_r <= 1'b1;
          words_r    <= words_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_word_s) begin
            // Address is held on the last word so it never points past N-1.
            state_r <= CSUM;
          end else begin
            idx_r   <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_r <= HI;
          end
        end
        CSUM: begin
          if (xfer_s) begin
            in_ready_r <= 1'b0;
            if (in_data == csum_r) begin
              load_done_r <= 1'b1;
              cpu_run_r   <= 1'b1;
              state_r     <= DONE;
            end else begin
              load_err_r <= 1'b1;
              cpu_run_r  <= 1'b0;
              state_r    <= ERR;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            cpu_run_r   <= 1'b0;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
            words_r     <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            state_r     <= HDR;
          end
        end
        default: begin
          state_r     <= HDR;
          in_ready_r  <= 1'b0;
          mem_we_r    <= 1'b0;
          cpu_run_r   <= 1'b0;
          load_done_r <= 1'b0;
          load_err_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = idx_r;
  assign mem_wdata    = wdata_r;
  assign cpu_run      = cpu_run_r;
  assign load_done    = load_done_r;
  assign load_err     = load_err_r;
  assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames, expected memory writes queued
// as each frame is issued and checked by an independent write monitor.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_run;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] wq[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: pops one expected write per strobe, also checks no byte
  // can be accepted while the write cycle is in progress.
  always @(negedge clk) begin
    wr_t e;
    if (reset && mem_we) begin
      chk("in_ready_during_wr", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, e.d});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred,
  // leaving in_valid high so consecutive bytes can go back to back.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int c;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    c = 0;
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got in_ready=0, expected 1 for byte %0h", b);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    while (!(load_done || load_err) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_end_timeout: got no done/err, expected one");
    end
  endtask

  // Sends header, all words in wq (high byte first) and the checksum byte.
  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] cs, input int maxgap);
    for (int i = 0; i < wq.size(); i++) begin
      exp_q.push_back('{a: i[ADDR_W-1:0], d: wq[i]});
    end
    send_byte(hdr, maxgap);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i][15:8], maxgap);
      send_byte(wq[i][7:0], maxgap);
    end
    send_byte(cs, maxgap);
    idle();
    wait_end();
    chk("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic run, input int words);
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    chk({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, run});
    chk({tag, "_words_loaded"}, {23'd0, words_loaded}, words);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Re-arm from DONE/ERR; cpu_run was checked before the edge by the caller.
  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status({tag, "_rearm"}, 1'b0, 1'b0, 1'b0, 0);
    chk({tag, "_rearm_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic load_basic();
    wq.delete();
    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
  endtask

  initial begin
    logic [7:0] cs;

    // Reset state while reset is held low.
    #12;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    chk("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_after_first_edge", {31'd0, in_ready}, 32'd1);

    // Two-word good frame: 12^34^AB^CD = 40.
    load_basic();
    run_frame(8'h02, 8'h40, 0);
    check_status("basic", 1'b1, 1'b0, 1'b1, 2);
    chk("basic_in_ready_done", {31'd0, in_ready}, 32'd0);
    pulse_start("basic");

    // One-word frame with bad checksum (correct would be 22).
    wq.delete();
    wq.push_back(16'h0022);
    run_frame(8'h01, 8'h23, 0);
    check_status("badcs", 1'b0, 1'b1, 1'b0, 1);
    pulse_start("badcs");

    // Full 256-word frame, header 0.
    wq.delete();
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      wq.push_back({i[7:0], i[7:0] ^ 8'h5A});
      cs = cs ^ i[7:0] ^ (i[7:0] ^ 8'h5A);
    end
    run_frame(8'h00, cs, 0);
    check_status("full", 1'b1, 1'b0, 1'b1, 256);
    pulse_start("full");

    // Same two-word frame with random valid gaps.
    load_basic();
    run_frame(8'h02, 8'h40, 3);
    check_status("gaps", 1'b1, 1'b0, 1'b1, 2);
    pulse_start("gaps");

    // start during HI is ignored; start in DONE re-arms on one edge.
    load_basic();
    exp_q.push_back('{a: 8'd0, d: 16'h1234});
    exp_q.push_back('{a: 8'd1, d: 16'hABCD});
    send_byte(8'h02, 0);
    idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_hi_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_in_hi_words", {23'd0, words_loaded}, 32'd0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h40, 0);
    idle();
    wait_end();
    check_status("start_hi", 1'b1, 1'b0, 1'b1, 2);
    pulse_start("start_done");
    exp_q.push_back('{a: 8'd0, d: 16'h0022});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h22, 0);
    send_byte(8'h23, 0);
    idle();
    wait_end();
    chk("next_frame_writes", exp_q.size(), 32'd0);
    check_status("next_frame", 1'b0, 1'b1, 1'b0, 1);
    pulse_start("next_frame");

    // Reset mid-load after the high byte of word 1.
    exp_q.push_back('{a: 8'd0, d: 16'h1234});
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    idle();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midload");
    chk("midload_writes", exp_q.size(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("midload_in_ready_release", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    load_basic();
    run_frame(8'h02, 8'h40, 0);
    check_status("after_reset", 1'b1, 1'b0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
